// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter: FSM states,
// requester port ids and tie-break mode values.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD      = 2'd1,
    RD_WAIT = 2'd2,
    WR      = 2'd3
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  localparam int ARB_RR       = 0;
  localparam int ARB_FIXED_DM = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input combinational arbiter. Bit 0 is the fetch port and bit 1 is the data port.
// In fixed mode a tie always goes to the data port.
module rr_arbiter2
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       mode,
  output logic [1:0] gnt_next
);

  always_comb begin
    gnt_next = 2'b00;
    case (req)
      2'b01: gnt_next = 2'b01;
      2'b10: gnt_next = 2'b10;
      2'b11: begin
        // On a round-robin tie, grant the port that did not win last time.
        if (mode || (last_gnt == PORT_IF)) gnt_next = 2'b10;
        else                               gnt_next = 2'b01;
      end
      default: gnt_next = 2'b00;
    endcase
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data load/store.
// A read costs 3 cycles and a write costs 2. All outputs are registered.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_q,
  output logic              sram_we_n,
  input  logic [DATA_W-1:0] sram_d
);

  localparam logic MODE_FIXED = (ARB_MODE == ARB_FIXED_DM);

  state_t     state, state_next;
  logic       last_gnt;
  logic       owner;
  logic [1:0] gnt_next;
  logic       take, take_dm, take_wr;

  rr_arbiter2 u_arb (
    .req      ({dm_req, if_req}),
    .last_gnt (last_gnt),
    .mode     (MODE_FIXED),
    .gnt_next (gnt_next)
  );

  // Requests only count in IDLE. Once a port is granted, its inputs are ignored until the next IDLE.
  always_comb begin
    take    = (state == IDLE) && (gnt_next != 2'b00);
    take_dm = take && gnt_next[1];
    take_wr = take_dm && dm_we;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (take_wr)   state_next = WR;
        else if (take) state_next = RD;
      end
      RD:      state_next = RD_WAIT;
      RD_WAIT: state_next = IDLE;
      WR:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // sram_addr and sram_q are loaded only at a grant.
  // The write strobe is active for a single cycle, the WR cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt  <= PORT_DM;
      owner     <= PORT_IF;
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      sram_addr <= '0;
      sram_q    <= '0;
      sram_we_n <= 1'b1;
    end else begin
      if_gnt    <= take && !gnt_next[1];
      dm_gnt    <= take_dm;
      sram_we_n <= !take_wr;
      if_valid  <= (state == RD_WAIT) && (owner == PORT_IF);
      dm_valid  <= (state == RD_WAIT) && (owner == PORT_DM);
      if (take) begin
        last_gnt  <= gnt_next[1];
        owner     <= gnt_next[1];
        sram_addr <= gnt_next[1] ? dm_addr : if_addr;
      end
      if (take_wr) sram_q <= dm_wdata;
      if (state == RD_WAIT) begin
        if (owner == PORT_IF) if_rdata <= sram_d;
        else                  dm_rdata <= sram_d;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter. Instance 0 runs in round-robin mode and instance 1 in fixed mode.
// A transaction-level model is checked every cycle, and directed literals pin key results.
module tb_sram_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req    [2];
  logic [15:0] if_addr   [2];
  logic        if_gnt    [2];
  logic        if_valid  [2];
  logic [15:0] if_rdata  [2];
  logic        dm_req    [2];
  logic        dm_we     [2];
  logic [15:0] dm_addr   [2];
  logic [15:0] dm_wdata  [2];
  logic        dm_gnt    [2];
  logic        dm_valid  [2];
  logic [15:0] dm_rdata  [2];
  logic [15:0] sram_addr [2];
  logic [15:0] sram_q    [2];
  logic        sram_we_n [2];
  logic [15:0] sram_d    [2];

  int tests_run    = 0;
  int tests_failed = 0;
  bit chk_en       = 1'b0;

  sram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .ARB_MODE(0)) dut_rr (
    .clk(clk), .reset(reset),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
    .if_valid(if_valid[0]), .if_rdata(if_rdata[0]),
    .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]),
    .dm_wdata(dm_wdata[0]), .dm_gnt(dm_gnt[0]), .dm_valid(dm_valid[0]),
    .dm_rdata(dm_rdata[0]), .sram_addr(sram_addr[0]), .sram_q(sram_q[0]),
    .sram_we_n(sram_we_n[0]), .sram_d(sram_d[0])
  );

  sram_port_arbiter #(.ADDR_W(16), .DATA_W(16), .ARB_MODE(1)) dut_fx (
    .clk(clk), .reset(reset),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
    .if_valid(if_valid[1]), .if_rdata(if_rdata[1]),
    .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]),
    .dm_wdata(dm_wdata[1]), .dm_gnt(dm_gnt[1]), .dm_valid(dm_valid[1]),
    .dm_rdata(dm_rdata[1]), .sram_addr(sram_addr[1]), .sram_q(sram_q[1]),
    .sram_we_n(sram_we_n[1]), .sram_d(sram_d[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Preset contents of the SRAM and the model before any write.
  function automatic logic [15:0] init_word(input logic [15:0] a);
    case (a)
      16'h0010: return 16'hA5C3;
      16'h0011: return 16'h5A3C;
      default:  return {a[7:0], ~a[7:0]};
    endcase
  endfunction

  logic [15:0] sram0 [int];
  logic [15:0] sram1 [int];
  logic [15:0] mdl0  [int];
  logic [15:0] mdl1  [int];

  function automatic logic [15:0] sram_rd(input int d, input logic [15:0] a);
    if (d == 0) return sram0.exists(int'(a)) ? sram0[int'(a)] : init_word(a);
    else        return sram1.exists(int'(a)) ? sram1[int'(a)] : init_word(a);
  endfunction

  function automatic void sram_wr(input int d, input logic [15:0] a, input logic [15:0] v);
    if (d == 0) sram0[int'(a)] = v;
    else        sram1[int'(a)] = v;
  endfunction

  function automatic logic [15:0] mdl_rd(input int d, input logic [15:0] a);
    if (d == 0) return mdl0.exists(int'(a)) ? mdl0[int'(a)] : init_word(a);
    else        return mdl1.exists(int'(a)) ? mdl1[int'(a)] : init_word(a);
  endfunction

  function automatic void mdl_wr(input int d, input logic [15:0] a, input logic [15:0] v);
    if (d == 0) mdl0[int'(a)] = v;
    else        mdl1[int'(a)] = v;
  endfunction

  // Synchronous-read SRAM: the word addressed in one cycle appears on sram_d in the next.
  initial begin
    sram_d[0] = '0;
    sram_d[1] = '0;
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        sram_d[d] <= sram_rd(d, sram_addr[d]);
        if (sram_we_n[d] == 1'b0) sram_wr(d, sram_addr[d], sram_q[d]);
      end
    end
  end

  // Transaction model: the busy countdown, the pending read or write, and the expected outputs.
  int          m_rem     [2];
  bit          m_rd_pend [2];
  bit          m_rd_dm   [2];
  logic [15:0] m_rd_addr [2];
  bit          m_wr_pend [2];
  logic [15:0] m_wr_addr [2];
  logic [15:0] m_wr_data [2];
  bit          m_last_dm [2];
  logic        e_if_gnt  [2];
  logic        e_dm_gnt  [2];
  logic        e_if_valid[2];
  logic        e_dm_valid[2];
  logic        e_we_n    [2];
  logic [15:0] e_if_rdata[2];
  logic [15:0] e_dm_rdata[2];
  logic [15:0] e_addr    [2];
  logic [15:0] e_q       [2];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_rem[d] = 0;  m_rd_pend[d] = 0; m_rd_dm[d] = 0; m_rd_addr[d] = '0;
      m_wr_pend[d] = 0; m_wr_addr[d] = '0; m_wr_data[d] = '0;
      m_last_dm[d] = 1'b1;
      e_if_gnt[d] = 0; e_dm_gnt[d] = 0; e_if_valid[d] = 0; e_dm_valid[d] = 0;
      e_we_n[d] = 1'b1; e_if_rdata[d] = '0; e_dm_rdata[d] = '0;
      e_addr[d] = '0; e_q[d] = '0;
    end
  endfunction

  function automatic void model_step(input int d);
    bit          win_dm;
    logic [15:0] v;
    e_if_gnt[d] = 0; e_dm_gnt[d] = 0; e_if_valid[d] = 0; e_dm_valid[d] = 0;
    e_we_n[d] = 1'b1;
    if (m_rem[d] == 0) begin
      if (if_req[d] || dm_req[d]) begin
        if (if_req[d] && dm_req[d]) win_dm = (d == 1) ? 1'b1 : !m_last_dm[d];
        else                        win_dm = dm_req[d];
        m_last_dm[d] = win_dm;
        if (win_dm) begin
          e_dm_gnt[d] = 1'b1;
          e_addr[d]   = dm_addr[d];
          if (dm_we[d]) begin
            e_we_n[d] = 1'b0; e_q[d] = dm_wdata[d];
            m_wr_pend[d] = 1; m_wr_addr[d] = dm_addr[d]; m_wr_data[d] = dm_wdata[d];
            m_rem[d] = 1;
          end else begin
            m_rd_pend[d] = 1; m_rd_dm[d] = 1; m_rd_addr[d] = dm_addr[d];
            m_rem[d] = 2;
          end
        end else begin
          e_if_gnt[d] = 1'b1;
          e_addr[d]   = if_addr[d];
          m_rd_pend[d] = 1; m_rd_dm[d] = 0; m_rd_addr[d] = if_addr[d];
          m_rem[d] = 2;
        end
      end
    end else begin
      m_rem[d] = m_rem[d] - 1;
      if (m_rem[d] == 0) begin
        if (m_wr_pend[d]) mdl_wr(d, m_wr_addr[d], m_wr_data[d]);
        m_wr_pend[d] = 0;
        if (m_rd_pend[d]) begin
          v = mdl_rd(d, m_rd_addr[d]);
          if (m_rd_dm[d]) begin e_dm_valid[d] = 1'b1; e_dm_rdata[d] = v; end
          else            begin e_if_valid[d] = 1'b1; e_if_rdata[d] = v; end
        end
        m_rd_pend[d] = 0;
      end
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (reset) model_reset();
      else for (int d = 0; d < 2; d++) model_step(d);
    end
  end

  initial begin
    forever begin
      @(posedge reset);
      model_reset();
    end
  end

  task automatic checkOutput(input string name, input int d, input logic [15:0] act,
                             input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s dut%0d at %0t: got %h expected %h", name, d, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int d = 0; d < 2; d++) begin
          checkOutput("if_gnt",    d, {15'd0, if_gnt[d]},    {15'd0, e_if_gnt[d]});
          checkOutput("dm_gnt",    d, {15'd0, dm_gnt[d]},    {15'd0, e_dm_gnt[d]});
          checkOutput("if_valid",  d, {15'd0, if_valid[d]},  {15'd0, e_if_valid[d]});
          checkOutput("dm_valid",  d, {15'd0, dm_valid[d]},  {15'd0, e_dm_valid[d]});
          checkOutput("sram_we_n", d, {15'd0, sram_we_n[d]}, {15'd0, e_we_n[d]});
          checkOutput("if_rdata",  d, if_rdata[d],  e_if_rdata[d]);
          checkOutput("dm_rdata",  d, dm_rdata[d],  e_dm_rdata[d]);
          checkOutput("sram_addr", d, sram_addr[d], e_addr[d]);
          checkOutput("sram_q",    d, sram_q[d],    e_q[d]);
        end
      end
    end
  end

  // Grant order log: 0 = fetch, 1 = data.
  int glog0 [$];
  int glog1 [$];
  initial begin
    forever begin
      @(negedge clk);
      if (if_gnt[0]) glog0.push_back(0);
      if (dm_gnt[0]) glog0.push_back(1);
      if (if_gnt[1]) glog1.push_back(0);
      if (dm_gnt[1]) glog1.push_back(1);
    end
  end

  // Raise one request and hold it until its grant, then drop it. Returns at the grant cycle.
  task automatic applyStimulus(input int d, input bit dm, input logic we,
                               input logic [15:0] addr, input logic [15:0] wdata,
                               output int lat);
    bit got;
    if (dm) begin
      dm_req[d] = 1'b1; dm_we[d] = we; dm_addr[d] = addr; dm_wdata[d] = wdata;
    end else begin
      if_req[d] = 1'b1; if_addr[d] = addr;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      got = dm ? dm_gnt[d] : if_gnt[d];
    end
    if (!got) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL grant_timeout dut%0d: got no grant expected grant within 20 cycles", d);
    end
    if (dm) dm_req[d] = 1'b0;
    else    if_req[d] = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int lat;
  int n;

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      if_req[d] = 0; if_addr[d] = '0; dm_req[d] = 0; dm_we[d] = 0;
      dm_addr[d] = '0; dm_wdata[d] = '0;
    end
    model_reset();
    @(negedge clk);
    chk_en = 1'b1;
    checkOutput("reset_we_n", 0, {15'd0, sram_we_n[0]}, 16'd1);
    checkOutput("reset_addr", 0, sram_addr[0], 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // Single fetch
    applyStimulus(0, 0, 0, 16'h0010, 16'h0, lat);
    checkOutput("fetch_gnt_latency", 0, 16'(lat), 16'd1);
    checkOutput("fetch_addr_c1", 0, sram_addr[0], 16'h0010);
    @(negedge clk);
    checkOutput("fetch_addr_c2", 0, sram_addr[0], 16'h0010);
    @(negedge clk);
    checkOutput("fetch_valid_c3", 0, {15'd0, if_valid[0]}, 16'd1);
    checkOutput("fetch_rdata_c3", 0, if_rdata[0], 16'hA5C3);

    // Store, then load from the same address
    applyStimulus(0, 1, 1, 16'h0200, 16'h1234, lat);
    checkOutput("store_gnt_latency", 0, 16'(lat), 16'd1);
    checkOutput("store_we_n_c1", 0, {15'd0, sram_we_n[0]}, 16'd0);
    checkOutput("store_q_c1", 0, sram_q[0], 16'h1234);
    @(negedge clk);
    checkOutput("store_we_n_c2", 0, {15'd0, sram_we_n[0]}, 16'd1);
    checkOutput("store_no_valid", 0, {15'd0, dm_valid[0]}, 16'd0);
    applyStimulus(0, 1, 0, 16'h0200, 16'h0, lat);
    repeat (2) @(negedge clk);
    checkOutput("load_valid", 0, {15'd0, dm_valid[0]}, 16'd1);
    checkOutput("load_rdata", 0, dm_rdata[0], 16'h1234);

    // Round-robin contention with both requests held
    doReset();
    glog0.delete();
    if_addr[0] = 16'h0020; dm_addr[0] = 16'h0030; dm_we[0] = 1'b0;
    if_req[0] = 1'b1; dm_req[0] = 1'b1;
    repeat (12) @(negedge clk);
    if_req[0] = 1'b0; dm_req[0] = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("rr_grant_count", 0, 16'(glog0.size()), 16'd4);
    if (glog0.size() >= 4) begin
      checkOutput("rr_order0", 0, 16'(glog0[0]), 16'd0);
      checkOutput("rr_order1", 0, 16'(glog0[1]), 16'd1);
      checkOutput("rr_order2", 0, 16'(glog0[2]), 16'd0);
      checkOutput("rr_order3", 0, 16'(glog0[3]), 16'd1);
    end

    // Fixed priority on the second instance
    glog1.delete();
    if_addr[1] = 16'h0044; dm_addr[1] = 16'h0055; dm_we[1] = 1'b0;
    if_req[1] = 1'b1; dm_req[1] = 1'b1;
    n = 0; lat = 0;
    while (n < 3 && lat < 30) begin
      @(negedge clk);
      lat++;
      if (dm_gnt[1]) n++;
    end
    checkOutput("fixed_dm_grants", 1, 16'(n), 16'd3);
    dm_req[1] = 1'b0;
    lat = 0;
    while (!if_gnt[1] && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if_req[1] = 1'b0;
    checkOutput("fixed_if_after_drop", 1, 16'(lat), 16'd3);
    repeat (4) @(negedge clk);
    checkOutput("fixed_log_size", 1, 16'(glog1.size()), 16'd4);
    if (glog1.size() >= 4) begin
      checkOutput("fixed_order2", 1, 16'(glog1[2]), 16'd1);
      checkOutput("fixed_order3", 1, 16'(glog1[3]), 16'd0);
    end

    // Reset in the middle of a write cycle truncates the write
    applyStimulus(0, 1, 1, 16'h0300, 16'hBEEF, lat);
    #1 reset = 1'b1;
    #1 checkOutput("reset_wr_we_n", 0, {15'd0, sram_we_n[0]}, 16'd1);
    checkOutput("reset_wr_gnt", 0, {15'd0, dm_gnt[0]}, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 1, 0, 16'h0300, 16'h0, lat);
    repeat (2) @(negedge clk);
    checkOutput("truncated_store", 0, dm_rdata[0], 16'h00FF);

    // Reset during RD_WAIT suppresses the valid pulse
    applyStimulus(0, 0, 0, 16'h0010, 16'h0, lat);
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_rdwait_valid", 0, {15'd0, if_valid[0]}, 16'd0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 16'h0011, 16'h0, lat);
    checkOutput("post_reset_latency", 0, 16'(lat), 16'd1);
    repeat (2) @(negedge clk);
    checkOutput("post_reset_valid", 0, {15'd0, if_valid[0]}, 16'd1);
    checkOutput("post_reset_rdata", 0, if_rdata[0], 16'h5A3C);

    // A request pulsed only during RD_WAIT is never seen
    applyStimulus(0, 1, 0, 16'h0040, 16'h0, lat);
    @(negedge clk);
    if_addr[0] = 16'h0050; if_req[0] = 1'b1;
    @(negedge clk);
    if_req[0] = 1'b0;
    checkOutput("withdraw_load_rdata", 0, dm_rdata[0], 16'h40BF);
    repeat (4) begin
      @(negedge clk);
      checkOutput("withdraw_no_gnt", 0, {15'd0, if_gnt[0]}, 16'd0);
      checkOutput("withdraw_addr", 0, sram_addr[0], 16'h0040);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
